alarm_countdown_timer: RTL and testbench

- Seconds-based countdown timer for the car-alarm system.
- Sits between the time-parameter store and the main alarm FSM.
- Takes a 4-bit interval in seconds, selected and supplied upstream by the time-parameter block, and reports `expired` back to the FSM.
- Also generates the 1 Hz and 0.5 Hz enable strobes, plus a 2 s-period blink level that drives the status LED.

---
 rtl/alarm_timer_pkg.sv | 13 +
 rtl/alarm_countdown_timer_one_hz_prescaler.sv | 51 +++++
 rtl/alarm_countdown_timer.sv | 110 +++++++++++
 tb/tb_alarm_countdown_timer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_timer_pkg.sv
// Shared definitions for the car-alarm countdown timer: FSM state encoding
// and the default width of the seconds counter.
package alarm_timer_pkg;

  localparam int VALUE_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    DONE  = 2'b10
  } timer_state_t;

endpackage

// File: rtl/alarm_countdown_timer_one_hz_prescaler.sv
// one_hz_prescaler: free-running 0..CLK_FREQ_HZ-1 prescaler that produces the
// internal seconds tick, the registered 1 Hz / 0.5 Hz enable strobes and the
// status LED blink level. A synchronous restart forces the prescaler to 0 so a
// freshly started countdown begins on an exact second boundary; the strobe is
// suppressed in that cycle and the global strobes re-phase from there.
module one_hz_prescaler #(
  parameter int CLK_FREQ_HZ = 50000000
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic tick,
  output logic one_hz_enable,
  output logic half_hz_enable,
  output logic status_blink
);

  localparam int PRE_W = (CLK_FREQ_HZ > 2) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_FREQ_HZ - 1);

  logic [PRE_W-1:0] prescaler;
  logic             blink_tog;

  // Terminal count of the prescaler marks the end of each second.
  assign tick         = (prescaler == PRE_MAX);
  assign status_blink = blink_tog;

  // Prescaler, half-Hz toggle and registered strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescaler      <= '0;
      blink_tog      <= 1'b0;
      one_hz_enable  <= 1'b0;
      half_hz_enable <= 1'b0;
    end else if (restart) begin
      prescaler      <= '0;
      one_hz_enable  <= 1'b0;
      half_hz_enable <= 1'b0;
    end else if (tick) begin
      prescaler      <= '0;
      one_hz_enable  <= 1'b1;
      half_hz_enable <= blink_tog;
      blink_tog      <= ~blink_tog;
    end else begin
      prescaler      <= prescaler + PRE_W'(1);
      one_hz_enable  <= 1'b0;
      half_hz_enable <= 1'b0;
    end
  end

endmodule

// File: rtl/alarm_countdown_timer.sv
// alarm_countdown_timer: seconds-based countdown for the car-alarm FSM.
// A rising edge on start_timer loads `value` and counts it down once per
// second; `expired` is held high once the count reaches 0 until start_timer
// drops. Also exports the 1 Hz / 0.5 Hz strobes and the status LED blink.
// Optional: define TIMER_REMAINING_EN to expose the live seconds counter on
// the `remaining` output.
module alarm_countdown_timer
  import alarm_timer_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int VALUE_W     = VALUE_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [VALUE_W-1:0] value,
  input  logic               start_timer,
  output logic               expired,
  output logic               one_hz_enable,
  output logic               half_hz_enable,
`ifdef TIMER_REMAINING_EN
  output logic               status_blink,
  output logic [VALUE_W-1:0] remaining
`else
  output logic               status_blink
`endif
);

  timer_state_t       state;
  logic [VALUE_W-1:0] seconds;
  logic               start_d;
  logic               start_rise;
  logic               tick;

  // A restart is recognised only on the sampled low-to-high transition, so a
  // held start never retriggers.
  assign start_rise = start_timer & ~start_d;

`ifdef TIMER_REMAINING_EN
  assign remaining = seconds;
`endif

  one_hz_prescaler #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_prescaler (
    .clock         (clock),
    .reset         (reset),
    .restart       (start_rise),
    .tick          (tick),
    .one_hz_enable (one_hz_enable),
    .half_hz_enable(half_hz_enable),
    .status_blink  (status_blink)
  );

  // Countdown FSM: abort on start low, restart on start rise, else count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      seconds <= '0;
      expired <= 1'b0;
      start_d <= 1'b0;
    end else begin
      start_d <= start_timer;
      if (!start_timer) begin
        state   <= IDLE;
        seconds <= '0;
        expired <= 1'b0;
      end else if (start_rise) begin
        if (value == '0) begin
          state   <= DONE;
          seconds <= '0;
          expired <= 1'b1;
        end else begin
          state   <= COUNT;
          seconds <= value;
          expired <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: begin
            seconds <= '0;
            expired <= 1'b0;
          end
          COUNT: begin
            if (tick) begin
              // The last second lands directly in DONE; the counter
              // never wraps below zero.
              if (seconds <= VALUE_W'(1)) begin
                state   <= DONE;
                seconds <= '0;
                expired <= 1'b1;
              end else begin
                seconds <= seconds - VALUE_W'(1);
              end
            end
          end
          DONE: begin
            seconds <= '0;
            expired <= 1'b1;
          end
          default: begin
            state   <= IDLE;
            seconds <= '0;
            expired <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alarm_countdown_timer.sv
// Scoreboard bench for alarm_countdown_timer with CLK_FREQ_HZ=4. The stimulus
// process drives inputs on the falling edge and pushes the reference model's
// prediction for the next rising edge; a monitor pops and compares after it.
module tb_alarm_countdown_timer;

  localparam int N = 4;
  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] value;
  logic         start_timer;
  logic         expired;
  logic         one_hz_enable;
  logic         half_hz_enable;
  logic         status_blink;
  logic [W-1:0] remaining;

  always #5 clock = ~clock;

  alarm_countdown_timer #(
    .CLK_FREQ_HZ(N),
    .VALUE_W    (W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .value         (value),
    .start_timer   (start_timer),
    .expired       (expired),
    .one_hz_enable (one_hz_enable),
    .half_hz_enable(half_hz_enable),
`ifdef TIMER_REMAINING_EN
    .status_blink  (status_blink),
    .remaining     (remaining)
`else
    .status_blink  (status_blink)
`endif
  );

`ifndef TIMER_REMAINING_EN
  assign remaining = '0;
`endif

  typedef struct {
    logic         exp;
    logic         one;
    logic         half;
    logic         blink;
    logic [W-1:0] rem;
    longint       edge_no;
  } pred_t;

  pred_t sbq[$];
  int    total = 0;
  int    bad   = 0;

  // Reference model state, in terms of absolute edge numbers.
  longint e_now;      // number of the last rising edge already predicted
  longint phase_ref;  // edge after which the prescaler read 0
  longint run_start;  // edge at which the running countdown was loaded
  int     run_len;    // seconds loaded at run_start
  bit     running;
  bit     m_exp;
  bit     m_prev;
  bit     m_tog;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, req, $time);
    end
  endtask

  // Predict outputs after rising edge number ed for the given inputs.
  task automatic model_edge(input longint ed, input bit st, input int v, input bit r,
                            output pred_t p);
    bit rise;
    bit one;
    bit half;
    one  = 0;
    half = 0;
    if (r) begin
      phase_ref = ed;
      running   = 0;
      m_exp     = 0;
      m_prev    = 0;
      m_tog     = 0;
    end else begin
      rise = st && !m_prev;
      // Strobes: a restart re-phases the second; otherwise every N edges.
      if (rise) begin
        phase_ref = ed;
      end else if (((ed - phase_ref) % N) == 0) begin
        one   = 1;
        half  = m_tog;
        m_tog = !m_tog;
      end
      // Countdown: expiry exactly v seconds after the load edge.
      if (!st) begin
        running = 0;
        m_exp   = 0;
      end else if (rise) begin
        if (v == 0) begin
          running = 0;
          m_exp   = 1;
        end else begin
          running   = 1;
          run_start = ed;
          run_len   = v;
          m_exp     = 0;
        end
      end else if (running && ed == run_start + longint'(run_len) * N) begin
        running = 0;
        m_exp   = 1;
      end
      m_prev = st;
    end
    p.exp     = m_exp;
    p.one     = one;
    p.half    = half;
    p.blink   = m_tog;
    p.rem     = running ? W'(run_len - int'((ed - run_start) / N)) : '0;
    p.edge_no = ed;
  endtask

  // One clock of stimulus: drive on the falling edge, predict the next edge.
  task automatic step(input bit st, input int v, input bit r);
    pred_t p;
    @(negedge clock);
    value       = W'(v);
    start_timer = st;
    if (r && !reset) begin
      reset = 1'b1;
      #1;
      chk("async_reset_expired", expired, 0);
      chk("async_reset_one_hz", one_hz_enable, 0);
      chk("async_reset_half_hz", half_hz_enable, 0);
      chk("async_reset_blink", status_blink, 0);
    end else begin
      reset = r;
    end
    model_edge(e_now + 1, st, v, r, p);
    e_now = e_now + 1;
    sbq.push_back(p);
  endtask

  task automatic hold(input int n, input bit st, input int v);
    for (int i = 0; i < n; i++) step(st, v, 1'b0);
  endtask

  // Monitor: compare every predicted edge just after it happens.
  always @(posedge clock) begin
    pred_t p;
    #1;
    if (sbq.size() > 0) begin
      p = sbq.pop_front();
      chk($sformatf("expired@%0d", p.edge_no), expired, p.exp);
      chk($sformatf("one_hz@%0d", p.edge_no), one_hz_enable, p.one);
      chk($sformatf("half_hz@%0d", p.edge_no), half_hz_enable, p.half);
      chk($sformatf("blink@%0d", p.edge_no), status_blink, p.blink);
`ifdef TIMER_REMAINING_EN
      chk($sformatf("remaining@%0d", p.edge_no), remaining, p.rem);
`endif
    end
  end

  initial begin
    bit st;
    int v;
    reset       = 1'b1;
    start_timer = 1'b0;
    value       = '0;
    // Edge 1 happens under reset; the model starts from that point.
    e_now     = 1;
    phase_ref = 1;
    running   = 0;
    m_exp     = 0;
    m_prev    = 0;
    m_tog     = 0;
    run_start = 0;
    run_len   = 0;
    #2;
    chk("reset_expired", expired, 0);
    chk("reset_one_hz", one_hz_enable, 0);
    chk("reset_half_hz", half_hz_enable, 0);
    chk("reset_blink", status_blink, 0);
    chk("reset_remaining", remaining, 0);
    step(1'b0, 0, 1'b1);

    // Idle strobes.
    hold(16, 1'b0, 0);
    // Three-second countdown, held after expiry, then abort.
    hold(16, 1'b1, 3);
    hold(2, 1'b0, 3);
    // Zero-length countdown expires at once.
    hold(3, 1'b1, 0);
    hold(2, 1'b0, 0);
    // Abort mid-count, then a two-second run.
    hold(9, 1'b1, 5);
    hold(2, 1'b0, 5);
    hold(10, 1'b1, 2);
    hold(2, 1'b0, 2);
    // Asynchronous reset mid-count; start is cycled before the next run.
    hold(5, 1'b1, 2);
    step(1'b1, 2, 1'b1);
    step(1'b0, 2, 1'b1);
    hold(3, 1'b0, 2);
    hold(10, 1'b1, 2);
    hold(2, 1'b0, 2);
    // Start glitch around the final tick of a one-second run.
    hold(3, 1'b1, 1);
    step(1'b0, 1, 1'b0);
    step(1'b1, 2, 1'b0);
    hold(10, 1'b1, 2);
    hold(2, 1'b0, 2);

    // Randomised run: occasional start toggles and resets, value varies
    // freely (including during a countdown).
    st = 0;
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15))
                                      : int'($urandom_range(0, 4));
      if ($urandom_range(0, 299) == 0) begin
        st = 0;
        step(1'b0, v, 1'b1);
      end else begin
        if ($urandom_range(0, 29) == 0) st = !st;
        step(st, v, 1'b0);
      end
    end

    repeat (2) @(negedge clock);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
